cpu_multicycle_controller: RTL and testbench
============================================

CPU_MULTICYCLE_CONTROLLER -- requirements
Module: cpu_multicycle_controller

Interface
REQ-001 Parameter MEM_TIMEOUT, default 16, meaning: max consecutive wait cycles per memory request; 0 disables timeout.
REQ-002 Parameter ENABLE_UPPER, default 1, meaning: 1 = LUI/AUIPC/JALR legal; 0 = these opcodes trap as illegal.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 run  input  1  1 = fetch instructions; 0 = park in IDLE at next instruction boundary.
REQ-006 opcode  input  7  instruction-register opcode field; valid from the cycle after ir_write.
REQ-007 branch_taken  input  1  comparator result; sampled only in EXEC of a branch.
REQ-008 mem_ready  input  1  memory completes current request this cycle.
REQ-009 mem_req / mem_we  output  1 each  memory request strobe; write qualifier.
REQ-010 ir_write, pc_write  output  1 each  instruction-register load; PC load.
REQ-011 pc_src  output  2  00 PC+4, 01 branch target, 10 JAL target, 11 JALR target.
REQ-012 alu_src, mem_to_reg, register_write, get_counter  output  1 each  datapath selects/enables, same meaning as the single-cycle controller.
REQ-013 alu_op  output  2  10 R/I-type, 01 branch/JAL, 00 add (load, store, LUI, AUIPC, JALR).
REQ-014 illegal_instr, timeout  output  1 each  sticky trap causes.
REQ-015 state  output  3  current FSM state, for debug.

Function
REQ-016 States: IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP; all outputs Moore-decoded from state and latched opcode, except FETCH/MEM completion strobes, which are qualified by mem_ready.
REQ-017 IDLE: all strobes 0; run=1 -> FETCH.
REQ-018 FETCH: mem_req=1, mem_we=0; on mem_ready: ir_write=1, pc_write=1, pc_src=00, -> DECODE; otherwise hold.
REQ-019 DECODE: exactly 1 cycle; latch opcode into opcode_q; legal opcode -> EXEC, else illegal_instr=1 -> TRAP.
REQ-020 Legal set: 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, plus 0110111, 0010111, 1100111 when ENABLE_UPPER=1.
REQ-021 EXEC: alu_op/alu_src from opcode_q; branch: pc_write=branch_taken, pc_src=01, -> FETCH; load/store -> MEM; JAL -> WB with pc_write=1, pc_src=10; JALR -> WB with pc_write=1, pc_src=11; others -> WB.
REQ-022 MEM: mem_req=1, mem_we=1 for store only; on mem_ready: load -> WB, store -> FETCH.
REQ-023 WB: register_write=1 for 1 cycle; mem_to_reg=1 for load; get_counter=1 for JAL/JALR; -> FETCH.
REQ-024 Every transition into FETCH goes to IDLE instead when run=0 in that cycle; run is never sampled mid-instruction.
REQ-025 register_write=0 and mem_we=0 in every state not listed above; a store never asserts register_write.
REQ-026 Timeout counter: clears on every state entry; increments each cycle with mem_req=1 and mem_ready=0; reaching MEM_TIMEOUT (>0) sets timeout=1 -> TRAP the next cycle; mem_ready in the same cycle as the limit wins.
REQ-027 Counter width is clog2(MEM_TIMEOUT+1), minimum 1, and it never wraps.
REQ-028 TRAP: all strobes 0; exits only via rst; run is ignored.
REQ-029 Latency: R/I 4 cycles, branch 3, store 4, load 5, JAL 4 (zero-wait memory).

Reset
REQ-030 rst=1 forces state=IDLE, opcode_q=0, counter=0, illegal_instr=0, timeout=0, all strobes 0, pc_src=00, alu_op=00, asynchronously.
REQ-031 rst asserted mid-instruction (including during a pending mem_req) aborts it with no further strobes; the first FETCH follows the first edge after release with run=1.

Structure
REQ-032 Package cpu_ctrl_pkg holds the state encoding, opcode constants, alu_op encodings and pc_src encodings.
REQ-033 A single sub-module mem_timeout_counter (parameter MEM_TIMEOUT) implements REQ-026/027; everything else is in the top module.

Verification
REQ-034 Add R-type (0110011), mem_ready=1, run=1: state sequence FETCH,DECODE,EXEC,WB; register_write high exactly 1 cycle; alu_op=10.
REQ-035 Load (0000011) with 3 wait cycles in FETCH and 2 in MEM -> mem_req held high throughout; WB has mem_to_reg=1, register_write=1.
REQ-036 Branch (1100011), branch_taken=1 -> pc_write=1, pc_src=01 in EXEC, no register_write; branch_taken=0 -> pc_write=0.
REQ-037 MEM_TIMEOUT=4, mem_ready stuck 0 in MEM -> timeout=1 after 4 wait cycles, state=TRAP, holds until rst.
REQ-038 ENABLE_UPPER=0, opcode 0110111 -> illegal_instr=1 and TRAP after DECODE; with ENABLE_UPPER=1 -> WB with alu_op=00.
REQ-039 rst pulsed during MEM of a store -> mem_we drops immediately, state=IDLE, no write completes.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multi-cycle CPU controller: FSM states, RV32 opcodes,
// ALU-operation and PC-source selects, plus small opcode-decode helpers.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_TRAP   = 3'd6
  } state_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [1:0] ALU_ADD    = 2'b00;
  localparam logic [1:0] ALU_BRANCH = 2'b01;
  localparam logic [1:0] ALU_RI     = 2'b10;

  localparam logic [1:0] PC_PLUS4  = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JAL    = 2'b10;
  localparam logic [1:0] PC_JALR   = 2'b11;

  // Upper-immediate and JALR forms are only legal when the build enables them.
  function automatic logic is_legal(logic [6:0] op, bit enable_upper);
    case (op)
      OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL: return 1'b1;
      OP_LUI, OP_AUIPC, OP_JALR:                        return enable_upper;
      default:                                          return 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] alu_op_for(logic [6:0] op);
    case (op)
      OP_R, OP_I:         return ALU_RI;
      OP_BRANCH, OP_JAL:  return ALU_BRANCH;
      default:            return ALU_ADD;
    endcase
  endfunction

  // Second ALU operand is the immediate for everything except register-register and compare/jump forms.
  function automatic logic uses_imm(logic [6:0] op);
    return !(op == OP_R || op == OP_BRANCH || op == OP_JAL);
  endfunction

endpackage

// File: rtl/cpu_multicycle_controller_if.sv
// Memory request/acknowledge handshake between the controller (master) and memory (slave).
interface cpu_multicycle_controller_if;
  logic mem_req;
  logic mem_we;
  logic mem_ready;

  modport master (output mem_req, output mem_we, input mem_ready);
  modport slave  (input mem_req, input mem_we, output mem_ready);
endinterface

// File: rtl/mem_timeout_counter.sv
// Counts consecutive memory wait cycles within one state; flags expiry on the wait cycle
// that reaches MEM_TIMEOUT. Saturates instead of wrapping; MEM_TIMEOUT=0 disables it.
module mem_timeout_counter #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic wait_cycle,
  output logic expired
);

  localparam int unsigned CW      = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam bit          ENABLED = (MEM_TIMEOUT > 0);
  localparam logic [CW-1:0] LIMIT = CW'(MEM_TIMEOUT);
  localparam logic [CW-1:0] LAST  = CW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  logic [CW-1:0] cnt_q, cnt_d;

  // Expiry looks only at the registered count so it never depends on the state-change clear.
  assign expired = ENABLED && wait_cycle && (cnt_q == LAST);

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (wait_cycle && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/cpu_multicycle_controller.sv
// Multi-cycle RV32 control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing with run-gated parking,
// sticky illegal-opcode and memory-timeout traps.
module cpu_multicycle_controller
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT  = 16,
  parameter bit          ENABLE_UPPER = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic [6:0] opcode,
  input  logic       branch_taken,
  cpu_multicycle_controller_if.master mem,
  output logic       ir_write,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       alu_src,
  output logic       mem_to_reg,
  output logic       register_write,
  output logic       get_counter,
  output logic [1:0] alu_op,
  output logic       illegal_instr,
  output logic       timeout,
  output logic [2:0] state
);

  state_e     state_q, state_d;
  logic [6:0] opcode_q, opcode_d;
  logic       illegal_instr_q, illegal_instr_d;
  logic       timeout_q, timeout_d;

  logic mem_req_o, mem_we_o, mem_wait, mem_expired, state_change;

  // Request strobe is purely state-decoded so the wait counter sees no loop through next-state logic.
  assign mem_req_o    = (state_q == ST_FETCH) || (state_q == ST_MEM);
  assign mem_we_o     = (state_q == ST_MEM) && (opcode_q == OP_STORE);
  assign mem_wait     = mem_req_o && !mem.mem_ready;
  assign state_change = (state_d != state_q);

  assign mem.mem_req  = mem_req_o;
  assign mem.mem_we   = mem_we_o;
  assign state        = state_q;
  assign illegal_instr = illegal_instr_q;
  assign timeout      = timeout_q;

  mem_timeout_counter #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timeout (
    .clk        (clk),
    .rst        (rst),
    .clear      (state_change),
    .wait_cycle (mem_wait),
    .expired    (mem_expired)
  );

  always_comb begin
    state_d         = state_q;
    opcode_d        = opcode_q;
    illegal_instr_d = illegal_instr_q;
    timeout_d       = timeout_q;
    ir_write        = 1'b0;
    pc_write        = 1'b0;
    pc_src          = PC_PLUS4;
    alu_src         = 1'b0;
    alu_op          = ALU_ADD;
    mem_to_reg      = 1'b0;
    register_write  = 1'b0;
    get_counter     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (run) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (mem.mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = ST_DECODE;
        end else if (mem_expired) begin
          timeout_d = 1'b1;
          state_d   = ST_TRAP;
        end
      end
      ST_DECODE: begin
        opcode_d = opcode;
        if (is_legal(opcode, ENABLE_UPPER)) begin
          state_d = ST_EXEC;
        end else begin
          illegal_instr_d = 1'b1;
          state_d         = ST_TRAP;
        end
      end
      ST_EXEC: begin
        alu_op  = alu_op_for(opcode_q);
        alu_src = uses_imm(opcode_q);
        case (opcode_q)
          OP_BRANCH: begin
            pc_write = branch_taken;
            pc_src   = PC_BRANCH;
            state_d  = run ? ST_FETCH : ST_IDLE;
          end
          OP_LOAD, OP_STORE: state_d = ST_MEM;
          OP_JAL: begin
            pc_write = 1'b1;
            pc_src   = PC_JAL;
            state_d  = ST_WB;
          end
          OP_JALR: begin
            pc_write = 1'b1;
            pc_src   = PC_JALR;
            state_d  = ST_WB;
          end
          default: state_d = ST_WB;
        endcase
      end
      ST_MEM: begin
        if (mem.mem_ready) begin
          if (opcode_q == OP_STORE) state_d = run ? ST_FETCH : ST_IDLE;
          else                      state_d = ST_WB;
        end else if (mem_expired) begin
          timeout_d = 1'b1;
          state_d   = ST_TRAP;
        end
      end
      ST_WB: begin
        register_write = 1'b1;
        mem_to_reg     = (opcode_q == OP_LOAD);
        get_counter    = (opcode_q == OP_JAL) || (opcode_q == OP_JALR);
        state_d        = run ? ST_FETCH : ST_IDLE;
      end
      ST_TRAP: state_d = ST_TRAP;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      opcode_q        <= '0;
      illegal_instr_q <= 1'b0;
      timeout_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      opcode_q        <= opcode_d;
      illegal_instr_q <= illegal_instr_d;
      timeout_q       <= timeout_d;
    end
  end

endmodule

// File: tb/tb_cpu_multicycle_controller.sv
// Scoreboard bench: per-cycle expected controller outputs are queued with their stimulus,
// then driven and compared cycle by cycle on two builds (upper opcodes on and off).
module tb_cpu_multicycle_controller;
  import cpu_ctrl_pkg::*;

  typedef struct packed {
    logic [2:0] state;
    logic       mem_req, mem_we, ir_write, pc_write;
    logic [1:0] pc_src;
    logic       alu_src;
    logic [1:0] alu_op;
    logic       mem_to_reg, register_write, get_counter, illegal_instr, timeout;
  } obs_t;

  typedef struct {
    string      name;
    obs_t       exp;
    logic [6:0] op;
    logic       taken, rdy, run;
    bit         use_b;
  } item_t;

  typedef struct {
    string      name;
    logic [6:0] op;
    logic       taken;
    logic [1:0] alu_op;
    logic       alu_src, pc_write;
    logic [1:0] pc_src;
    bit         has_mem, is_store, has_wb, mem_to_reg, get_counter;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       run = 1'b0, branch_taken = 1'b0, mem_ready = 1'b0;
  logic [6:0] opcode = '0;

  logic       ir_write [2], pc_write [2], alu_src [2], mem_to_reg [2];
  logic       register_write [2], get_counter [2], illegal_instr [2], timeout [2];
  logic [1:0] pc_src [2], alu_op [2];
  logic [2:0] state [2];

  cpu_multicycle_controller_if bus_a ();
  cpu_multicycle_controller_if bus_b ();
  assign bus_a.mem_ready = mem_ready;
  assign bus_b.mem_ready = mem_ready;

  cpu_multicycle_controller #(.MEM_TIMEOUT(4), .ENABLE_UPPER(1'b1)) dut_a (
    .clk(clk), .rst(rst), .run(run), .opcode(opcode), .branch_taken(branch_taken), .mem(bus_a),
    .ir_write(ir_write[0]), .pc_write(pc_write[0]), .pc_src(pc_src[0]), .alu_src(alu_src[0]),
    .mem_to_reg(mem_to_reg[0]), .register_write(register_write[0]), .get_counter(get_counter[0]),
    .alu_op(alu_op[0]), .illegal_instr(illegal_instr[0]), .timeout(timeout[0]), .state(state[0])
  );

  cpu_multicycle_controller #(.MEM_TIMEOUT(16), .ENABLE_UPPER(1'b0)) dut_b (
    .clk(clk), .rst(rst), .run(run), .opcode(opcode), .branch_taken(branch_taken), .mem(bus_b),
    .ir_write(ir_write[1]), .pc_write(pc_write[1]), .pc_src(pc_src[1]), .alu_src(alu_src[1]),
    .mem_to_reg(mem_to_reg[1]), .register_write(register_write[1]), .get_counter(get_counter[1]),
    .alu_op(alu_op[1]), .illegal_instr(illegal_instr[1]), .timeout(timeout[1]), .state(state[1])
  );

  always #5 clk = ~clk;

  int    n_vec  = 0;
  int    n_miss = 0;
  item_t sb[$];

  function automatic obs_t mk(state_e st);
    obs_t o;
    o       = '0;
    o.state = st;
    return o;
  endfunction

  function automatic obs_t sample(bit b);
    obs_t o;
    int   i;
    i                = b ? 1 : 0;
    o.state          = state[i];
    o.mem_req        = b ? bus_b.mem_req : bus_a.mem_req;
    o.mem_we         = b ? bus_b.mem_we  : bus_a.mem_we;
    o.ir_write       = ir_write[i];
    o.pc_write       = pc_write[i];
    o.pc_src         = pc_src[i];
    o.alu_src        = alu_src[i];
    o.alu_op         = alu_op[i];
    o.mem_to_reg     = mem_to_reg[i];
    o.register_write = register_write[i];
    o.get_counter    = get_counter[i];
    o.illegal_instr  = illegal_instr[i];
    o.timeout        = timeout[i];
    return o;
  endfunction

  task automatic check(string name, obs_t act, obs_t exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got state=%0d outs=%h, expected state=%0d outs=%h",
               name, act.state, act, exp.state, exp);
    end
  endtask

  task automatic push(string name, obs_t exp, logic [6:0] op, logic taken, logic rdy, logic r, bit use_b);
    item_t it;
    it.name  = name;
    it.exp   = exp;
    it.op    = op;
    it.taken = taken;
    it.rdy   = rdy;
    it.run   = r;
    it.use_b = use_b;
    sb.push_back(it);
  endtask

  // Each queued item owns one clock cycle: inputs driven just after the edge, outputs checked mid-cycle.
  task automatic run_queue();
    item_t it;
    while (sb.size() > 0) begin
      it = sb.pop_front();
      @(posedge clk);
      #1;
      opcode       = it.op;
      branch_taken = it.taken;
      mem_ready    = it.rdy;
      run          = it.run;
      @(negedge clk);
      check(it.name, sample(it.use_b), it.exp);
    end
  endtask

  task automatic push_instr(vec_t v);
    obs_t o;
    o = mk(ST_FETCH); o.mem_req = 1'b1; o.ir_write = 1'b1; o.pc_write = 1'b1;
    push({v.name, "/fetch"}, o, v.op, v.taken, 1'b1, 1'b1, 1'b0);
    push({v.name, "/decode"}, mk(ST_DECODE), v.op, v.taken, 1'b1, 1'b1, 1'b0);
    o = mk(ST_EXEC); o.alu_op = v.alu_op; o.alu_src = v.alu_src; o.pc_write = v.pc_write; o.pc_src = v.pc_src;
    push({v.name, "/exec"}, o, v.op, v.taken, 1'b1, 1'b1, 1'b0);
    if (v.has_mem) begin
      o = mk(ST_MEM); o.mem_req = 1'b1; o.mem_we = v.is_store;
      push({v.name, "/mem"}, o, v.op, v.taken, 1'b1, 1'b1, 1'b0);
    end
    if (v.has_wb) begin
      o = mk(ST_WB); o.register_write = 1'b1; o.mem_to_reg = v.mem_to_reg; o.get_counter = v.get_counter;
      push({v.name, "/wb"}, o, v.op, v.taken, 1'b1, 1'b1, 1'b0);
    end
  endtask

  // Leaves both controllers in IDLE with rst low, one cycle before the next edge.
  task automatic do_reset(string name);
    @(posedge clk);
    #1;
    rst = 1'b1; run = 1'b0; mem_ready = 1'b0; opcode = '0; branch_taken = 1'b0;
    @(negedge clk);
    check({name, "/reset_a"}, sample(1'b0), mk(ST_IDLE));
    check({name, "/reset_b"}, sample(1'b1), mk(ST_IDLE));
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[10];
    obs_t o;
    //          name        opcode       tkn alu_op src pcw pc_src mem  st   wb   m2r  gc
    vecs[0] = '{"add",      7'b0110011, 0, 2'b10, 0, 0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{"addi",     7'b0010011, 0, 2'b10, 1, 0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{"lw",       7'b0000011, 0, 2'b00, 1, 0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{"sw",       7'b0100011, 0, 2'b00, 1, 0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{"beq_t",    7'b1100011, 1, 2'b01, 0, 1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{"beq_nt",   7'b1100011, 0, 2'b01, 0, 0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{"jal",      7'b1101111, 0, 2'b01, 0, 1, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[7] = '{"jalr",     7'b1100111, 0, 2'b00, 1, 1, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[8] = '{"lui",      7'b0110111, 0, 2'b00, 1, 0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[9] = '{"auipc",    7'b0010111, 0, 2'b00, 1, 0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    // Zero-wait instructions back to back; sequence lengths pin down each latency.
    do_reset("table");
    run = 1'b1;
    for (int i = 0; i < 10; i++) begin
      push_instr(vecs[i]);
      run_queue();
    end

    // Load with 3 FETCH waits (ready lands on the last pre-limit cycle) and 2 MEM waits, then park.
    do_reset("ldwait");
    run = 1'b1;
    o = mk(ST_FETCH); o.mem_req = 1'b1;
    for (int i = 0; i < 3; i++) push("ldwait/fetch_wait", o, 7'b0000011, 1'b0, 1'b0, 1'b1, 1'b0);
    o.ir_write = 1'b1; o.pc_write = 1'b1;
    push("ldwait/fetch_done", o, 7'b0000011, 1'b0, 1'b1, 1'b1, 1'b0);
    push("ldwait/decode", mk(ST_DECODE), 7'b0000011, 1'b0, 1'b1, 1'b1, 1'b0);
    o = mk(ST_EXEC); o.alu_src = 1'b1;
    push("ldwait/exec", o, 7'b0000011, 1'b0, 1'b1, 1'b1, 1'b0);
    o = mk(ST_MEM); o.mem_req = 1'b1;
    for (int i = 0; i < 2; i++) push("ldwait/mem_wait", o, 7'b0000011, 1'b0, 1'b0, 1'b1, 1'b0);
    push("ldwait/mem_done", o, 7'b0000011, 1'b0, 1'b1, 1'b1, 1'b0);
    o = mk(ST_WB); o.register_write = 1'b1; o.mem_to_reg = 1'b1;
    push("ldwait/wb", o, 7'b0000011, 1'b0, 1'b1, 1'b0, 1'b0);
    push("ldwait/parked", mk(ST_IDLE), 7'b0000011, 1'b0, 1'b1, 1'b0, 1'b0);
    run_queue();

    // Illegal opcode traps after DECODE; TRAP ignores run and mem_ready.
    do_reset("illegal");
    run = 1'b1;
    o = mk(ST_FETCH); o.mem_req = 1'b1; o.ir_write = 1'b1; o.pc_write = 1'b1;
    push("illegal/fetch", o, 7'b1111111, 1'b0, 1'b1, 1'b1, 1'b0);
    push("illegal/decode", mk(ST_DECODE), 7'b1111111, 1'b0, 1'b1, 1'b1, 1'b0);
    o = mk(ST_TRAP); o.illegal_instr = 1'b1;
    for (int i = 0; i < 3; i++) push("illegal/trap", o, 7'b0110011, 1'b0, 1'b1, 1'(i % 2), 1'b0);
    run_queue();

    // MEM_TIMEOUT=4 with mem_ready stuck low in MEM: four wait cycles then a sticky timeout trap.
    do_reset("tmo");
    run = 1'b1;
    o = mk(ST_FETCH); o.mem_req = 1'b1; o.ir_write = 1'b1; o.pc_write = 1'b1;
    push("tmo/fetch", o, 7'b0000011, 1'b0, 1'b1, 1'b1, 1'b0);
    push("tmo/decode", mk(ST_DECODE), 7'b0000011, 1'b0, 1'b1, 1'b1, 1'b0);
    o = mk(ST_EXEC); o.alu_src = 1'b1;
    push("tmo/exec", o, 7'b0000011, 1'b0, 1'b1, 1'b1, 1'b0);
    o = mk(ST_MEM); o.mem_req = 1'b1;
    for (int i = 0; i < 4; i++) push("tmo/mem_wait", o, 7'b0000011, 1'b0, 1'b0, 1'b1, 1'b0);
    o = mk(ST_TRAP); o.timeout = 1'b1;
    for (int i = 0; i < 3; i++) push("tmo/trap", o, 7'b0000011, 1'b0, 1'(i == 1), 1'b1, 1'b0);
    run_queue();

    // Upper opcodes disabled: LUI traps as illegal on the second build.
    do_reset("upper_off");
    run = 1'b1;
    o = mk(ST_FETCH); o.mem_req = 1'b1; o.ir_write = 1'b1; o.pc_write = 1'b1;
    push("upper_off/fetch", o, 7'b0110111, 1'b0, 1'b1, 1'b1, 1'b1);
    push("upper_off/decode", mk(ST_DECODE), 7'b0110111, 1'b0, 1'b1, 1'b1, 1'b1);
    o = mk(ST_TRAP); o.illegal_instr = 1'b1;
    for (int i = 0; i < 2; i++) push("upper_off/trap", o, 7'b0110111, 1'b0, 1'b1, 1'b1, 1'b1);
    run_queue();

    // Reset asserted mid-cycle during a pending store: strobes drop at once, no write completes.
    do_reset("st_rst");
    run = 1'b1;
    o = mk(ST_FETCH); o.mem_req = 1'b1; o.ir_write = 1'b1; o.pc_write = 1'b1;
    push("st_rst/fetch", o, 7'b0100011, 1'b0, 1'b1, 1'b1, 1'b0);
    push("st_rst/decode", mk(ST_DECODE), 7'b0100011, 1'b0, 1'b1, 1'b1, 1'b0);
    o = mk(ST_EXEC); o.alu_src = 1'b1;
    push("st_rst/exec", o, 7'b0100011, 1'b0, 1'b1, 1'b1, 1'b0);
    o = mk(ST_MEM); o.mem_req = 1'b1; o.mem_we = 1'b1;
    push("st_rst/mem_pending", o, 7'b0100011, 1'b0, 1'b0, 1'b1, 1'b0);
    run_queue();
    #1;
    rst = 1'b1;
    #1;
    check("st_rst/async_drop", sample(1'b0), mk(ST_IDLE));
    @(posedge clk);
    #1;
    mem_ready = 1'b1;
    @(negedge clk);
    check("st_rst/held", sample(1'b0), mk(ST_IDLE));
    @(posedge clk);
    #1;
    rst = 1'b0;
    run = 1'b1;
    o = mk(ST_FETCH); o.mem_req = 1'b1;
    push("st_rst/first_fetch", o, 7'b0100011, 1'b0, 1'b0, 1'b1, 1'b0);
    run_queue();

    // run dropped mid-instruction is ignored until the boundary, then IDLE until run returns.
    do_reset("park");
    run = 1'b1;
    o = mk(ST_FETCH); o.mem_req = 1'b1; o.ir_write = 1'b1; o.pc_write = 1'b1;
    push("park/fetch", o, 7'b0110011, 1'b0, 1'b1, 1'b1, 1'b0);
    push("park/decode", mk(ST_DECODE), 7'b0110011, 1'b0, 1'b1, 1'b0, 1'b0);
    o = mk(ST_EXEC); o.alu_op = 2'b10;
    push("park/exec", o, 7'b0110011, 1'b0, 1'b1, 1'b0, 1'b0);
    o = mk(ST_WB); o.register_write = 1'b1;
    push("park/wb", o, 7'b0110011, 1'b0, 1'b1, 1'b0, 1'b0);
    push("park/idle", mk(ST_IDLE), 7'b0110011, 1'b0, 1'b1, 1'b0, 1'b0);
    push("park/idle_run", mk(ST_IDLE), 7'b0110011, 1'b0, 1'b1, 1'b1, 1'b0);
    o = mk(ST_FETCH); o.mem_req = 1'b1;
    push("park/refetch", o, 7'b0110011, 1'b0, 1'b0, 1'b1, 1'b0);
    run_queue();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
